// File: rtl/gh_uart_pkg.sv
// gh_uart_pkg
// Shared types and constants for the 16550-style UART receive path.
//   t_rx_state  : receiver FSM states
//   OVERSAMPLE  : xbrc enables per serial bit
//   MID_SAMPLE  : sample-counter load value giving the mid-bit point of the start bit
//   clamp_bits  : folds an out-of-range character length into 5..8
package gh_uart_pkg;

  typedef enum logic [2:0] {
    idle,
    r_start_bit,
    shift_data,
    r_parity,
    r_stop_bit,
    break_wait
  } t_rx_state;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  localparam logic [3:0] CNT_MID = 4'(MID_SAMPLE);
  localparam logic [3:0] CNT_BIT = 4'(OVERSAMPLE - 1);

  // An illegal length would otherwise let the bit counter wrap and index
  // outside the shift register; clamping keeps the frame bounded.
  function automatic logic [3:0] clamp_bits(input int n);
    if (n < 5)
      return 4'd5;
    else if (n > 8)
      return 4'd8;
    else
      return 4'(n);
  endfunction

endpackage

// File: rtl/gh_uart_rx_sampler.sv
// gh_uart_rx_sampler
// Two-flop synchronizer for the serial input plus the xbrc-gated sample
// down-counter. The counter reaching zero on an xbrc enable marks a sample point.
//   clk      : system clock
//   rst      : synchronous active-low reset
//   xbrc     : 16x baud enable, one clk wide
//   srx      : asynchronous serial input
//   load     : load the counter with load_val (wins over counting)
//   load_val : counter load value
//   rxs      : synchronized serial input
//   mid      : sample strobe (xbrc with counter at terminal count)
module gh_uart_rx_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       xbrc,
  input  logic       srx,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       rxs,
  output logic       mid
);

  logic       rx_meta;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      cnt     <= '0;
    end else begin
      rx_meta <= srx;
      rxs     <= rx_meta;
      if (load)
        cnt <= load_val;
      else if (xbrc)
        cnt <= cnt - 4'd1;
    end
  end

  assign mid = xbrc && (cnt == 4'd0);

endmodule

// File: rtl/gh_uart_rx_8bit.sv
// gh_uart_rx_8bit
// 16x-oversampling UART receiver, 5..8 data bits, optional parity, one stop
// bit sampled. Delivers each character with a one-cycle write strobe and
// per-character parity / framing / break flags.
//   clk       : system clock
//   rst       : synchronous active-low reset
//   xbrc      : 16x baud enable, one clk wide
//   srx       : asynchronous serial input, idles high
//   num_bits  : data bits per character (5..8), taken at start-bit validation
//   parity_en : parity bit present
//   parity_ev : 1 = even parity, 0 = odd
//   dout      : received character, right-aligned, upper bits zero
//   wr        : one-cycle write strobe to the Rx FIFO
//   parity_er : parity error, valid with wr
//   frame_er  : stop bit sampled low, valid with wr
//   break_itr : break character detected, valid with wr
//   busyn     : 1 while idle
//
// state       | meaning
// idle        | waiting for rxs low on an xbrc enable
// r_start_bit | counting to mid start bit to reject glitches
// shift_data  | sampling data bits at mid-bit
// r_parity    | sampling the parity bit
// r_stop_bit  | sampling the stop bit, issuing wr
// break_wait  | line held low after a break, waiting for it to go high
module gh_uart_rx_8bit
  import gh_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       xbrc,
  input  logic       srx,
  input  int         num_bits,
  input  logic       parity_en,
  input  logic       parity_ev,
  output logic [7:0] dout,
  output logic       wr,
  output logic       parity_er,
  output logic       frame_er,
  output logic       break_itr,
  output logic       busyn
);

  t_rx_state  state, state_nxt;

  logic       rxs;
  logic       mid;
  logic       cnt_load;
  logic [3:0] cnt_val;

  logic [7:0] sr;
  logic [3:0] bit_cnt;
  logic [3:0] nbits_q;
  logic       pen_q;
  logic       pev_q;
  logic       par_acc;
  logic       par_bit;
  logic       par_err;

  logic       start_ok;
  logic       shift_en;
  logic       par_smp;
  logic       stop_smp;
  logic       brk;
  logic [2:0] bit_idx;

  gh_uart_rx_sampler u_sampler (
    .clk      (clk),
    .rst      (rst),
    .xbrc     (xbrc),
    .srx      (srx),
    .load     (cnt_load),
    .load_val (cnt_val),
    .rxs      (rxs),
    .mid      (mid)
  );

  // bit_cnt counts down from nbits_q, so the first data bit lands at index 0.
  assign bit_idx = 3'(nbits_q - bit_cnt);

  // Break needs the parity bit low too; par_bit stays 0 when parity is absent.
  assign brk = !rxs && (sr == 8'd0) && !par_bit;

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = CNT_BIT;
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    par_smp   = 1'b0;
    stop_smp  = 1'b0;
    case (state)
      idle: begin
        if (xbrc && !rxs) begin
          state_nxt = r_start_bit;
          cnt_load  = 1'b1;
          cnt_val   = CNT_MID;
        end
      end
      r_start_bit: begin
        if (mid) begin
          if (rxs) begin
            state_nxt = idle;
          end else begin
            state_nxt = shift_data;
            cnt_load  = 1'b1;
            start_ok  = 1'b1;
          end
        end
      end
      shift_data: begin
        if (mid) begin
          shift_en = 1'b1;
          cnt_load = 1'b1;
          if (bit_cnt == 4'd1)
            state_nxt = pen_q ? r_parity : r_stop_bit;
        end
      end
      r_parity: begin
        if (mid) begin
          par_smp   = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = r_stop_bit;
        end
      end
      r_stop_bit: begin
        if (mid) begin
          stop_smp  = 1'b1;
          state_nxt = brk ? break_wait : idle;
        end
      end
      break_wait: begin
        if (xbrc && rxs)
          state_nxt = idle;
      end
      default: state_nxt = idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= idle;
      sr        <= '0;
      bit_cnt   <= '0;
      nbits_q   <= 4'd8;
      pen_q     <= 1'b0;
      pev_q     <= 1'b0;
      par_acc   <= 1'b0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
      dout      <= '0;
      wr        <= 1'b0;
      parity_er <= 1'b0;
      frame_er  <= 1'b0;
      break_itr <= 1'b0;
    end else begin
      state <= state_nxt;
      wr    <= stop_smp;
      if (start_ok) begin
        sr      <= '0;
        bit_cnt <= clamp_bits(num_bits);
        nbits_q <= clamp_bits(num_bits);
        pen_q   <= parity_en;
        pev_q   <= parity_ev;
        par_acc <= 1'b0;
        par_bit <= 1'b0;
        par_err <= 1'b0;
      end
      if (shift_en) begin
        sr[bit_idx] <= rxs;
        par_acc     <= par_acc ^ rxs;
        bit_cnt     <= bit_cnt - 4'd1;
      end
      // Parity error is held internally so the visible flag changes only with wr.
      if (par_smp) begin
        par_bit <= rxs;
        par_err <= (rxs != (pev_q ? par_acc : ~par_acc));
      end
      if (stop_smp) begin
        dout      <= sr;
        parity_er <= par_err;
        frame_er  <= ~rxs;
        break_itr <= brk;
      end
    end
  end

  assign busyn = (state == idle);

endmodule

// File: tb/tb_gh_uart_rx_8bit.sv
module tb_gh_uart_rx_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       xbrc = 1'b0;
  logic       srx = 1'b1;
  int         num_bits = 8;
  logic       parity_en = 1'b0;
  logic       parity_ev = 1'b0;
  logic [7:0] dout;
  logic       wr;
  logic       parity_er;
  logic       frame_er;
  logic       break_itr;
  logic       busyn;

  int checks = 0;
  int failures = 0;

  gh_uart_rx_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .xbrc      (xbrc),
    .srx       (srx),
    .num_bits  (num_bits),
    .parity_en (parity_en),
    .parity_ev (parity_ev),
    .dout      (dout),
    .wr        (wr),
    .parity_er (parity_er),
    .frame_er  (frame_er),
    .break_itr (break_itr),
    .busyn     (busyn)
  );

  always #5 clk = ~clk;

  // xbrc: one clk high every 4 clk
  logic [1:0] div = 2'd0;
  always @(posedge clk) begin
    div  <= div + 2'd1;
    xbrc <= (div == 2'd3);
  end

  int en_cnt = 0;
  always @(posedge clk) if (xbrc) en_cnt <= en_cnt + 1;

  // write-strobe monitor
  int         wr_cnt = 0;
  int         wr_en = 0;
  logic [7:0] cap_dout = 8'd0;
  logic       cap_pe = 1'b0;
  logic       cap_fe = 1'b0;
  logic       cap_bi = 1'b0;
  always @(negedge clk) begin
    if (wr) begin
      wr_cnt++;
      wr_en    = en_cnt;
      cap_dout = dout;
      cap_pe   = parity_er;
      cap_fe   = frame_er;
      cap_bi   = break_itr;
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int en_fall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    srx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int n, input logic pe,
                            input logic pbit, input logic stop, input int nstop);
    @(negedge clk);
    en_fall = en_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < n; i++) drive_bit(data[i]);
    if (pe) drive_bit(pbit);
    drive_bit(stop);
    for (int i = 1; i < nstop; i++) drive_bit(1'b1);
    srx = 1'b1;
  endtask

  // Reference: character result from the frame contents alone.
  task automatic run_char(input string tag, input logic [7:0] data, input int n,
                          input logic pe, input logic pev, input logic pbit,
                          input logic stop, input int nstop);
    logic [7:0] exp_d;
    logic       exp_pbit;
    logic       exp_pe, exp_fe, exp_bi;
    int         prev, exp_delta, delta;
    exp_d    = data & 8'((1 << n) - 1);
    exp_pbit = pev ? ^exp_d : ~^exp_d;
    exp_pe   = pe && (pbit != exp_pbit);
    exp_fe   = !stop;
    exp_bi   = !stop && (exp_d == 8'd0) && (!pe || !pbit);
    exp_delta = 8 + 16 * (n + 1 + int'(pe)) + 1;
    num_bits  = n;
    parity_en = pe;
    parity_ev = pev;
    prev = wr_cnt;
    send_frame(data, n, pe, pbit, stop, nstop);
    chk({tag, ".wr_count"}, wr_cnt - prev, 1);
    chk({tag, ".dout"}, cap_dout, exp_d);
    chk({tag, ".parity_er"}, cap_pe, exp_pe);
    chk({tag, ".frame_er"}, cap_fe, exp_fe);
    chk({tag, ".break_itr"}, cap_bi, exp_bi);
    delta = wr_en - en_fall;
    chk({tag, ".wr_timing"}, (delta == exp_delta || delta == exp_delta + 1), 1);
    repeat (240) @(negedge clk);
  endtask

  initial begin
    int       prev;
    int       n;
    logic     pe, pev, pbit, stop;
    logic [7:0] d;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.dout", dout, 0);
    chk("rst.wr", wr, 0);
    chk("rst.parity_er", parity_er, 0);
    chk("rst.frame_er", frame_er, 0);
    chk("rst.break_itr", break_itr, 0);
    chk("rst.busyn", busyn, 1);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    run_char("8n1_a5", 8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    run_char("7e1_35_p0", 8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    run_char("7e1_35_p1", 8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1);

    // reset in the middle of data bit 4 (8N1, data 0x0F)
    num_bits  = 8;
    parity_en = 1'b0;
    prev = wr_cnt;
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    srx = 1'b1;
    repeat (32) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.dout", dout, 0);
    chk("midrst.wr", wr, 0);
    chk("midrst.parity_er", parity_er, 0);
    chk("midrst.frame_er", frame_er, 0);
    chk("midrst.break_itr", break_itr, 0);
    chk("midrst.busyn", busyn, 1);
    rst = 1'b1;
    repeat (800) @(negedge clk);
    chk("midrst.no_wr", wr_cnt - prev, 0);
    run_char("5n2_1f", 8'h1F, 5, 1'b0, 1'b0, 1'b0, 1'b1, 2);

    run_char("8n1_3c_stoplow", 8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_char("8n1_81", 8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1);

    for (int k = 0; k < 10; k++) begin
      n    = $urandom_range(5, 8);
      pe   = 1'($urandom_range(0, 1));
      pev  = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      pbit = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 4) != 0);
      run_char($sformatf("rand%0d", k), d, n, pe, pev, pbit, stop, $urandom_range(1, 2));
    end

    // 4-enable glitch on idle line
    prev = wr_cnt;
    @(negedge clk);
    srx = 1'b0;
    repeat (16) @(negedge clk);
    srx = 1'b1;
    @(negedge clk);
    chk("glitch.busy", busyn, 0);
    repeat (40) @(negedge clk);
    chk("glitch.busyn_back", busyn, 1);
    chk("glitch.no_wr", wr_cnt - prev, 0);

    // break: line low for 3 character times
    num_bits  = 8;
    parity_en = 1'b0;
    prev = wr_cnt;
    @(negedge clk);
    srx = 1'b0;
    repeat (1920) @(negedge clk);
    chk("break.wr_count", wr_cnt - prev, 1);
    chk("break.dout", cap_dout, 0);
    chk("break.frame_er", cap_fe, 1);
    chk("break.break_itr", cap_bi, 1);
    chk("break.parity_er", cap_pe, 0);
    chk("break.waiting", busyn, 0);
    srx = 1'b1;
    repeat (24) @(negedge clk);
    chk("break.busyn_back", busyn, 1);
    repeat (200) @(negedge clk);
    chk("break.single_wr", wr_cnt - prev, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
